prescaled_counter: RTL and testbench

Parametrised up/down counter with a built-in prescaler, replacing the divider-plus-counter pair that clocks a counter from a divided clock. Everything runs on one clock: the prescaler produces a one-cycle enable instead of a derived clock. The counter adds width and range parameters, a runtime divide ratio, direction, a wrap or saturate mode, a synchronous load and a terminal-count pulse. It drives display/LED logic directly, with `q` feeding a seven-segment decoder.

---
 rtl/prescaled_counter.sv | 90 +++++++++
 tb/tb_prescaled_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   Single-clock up/down counter driven by a built-in prescaler. The
//   prescaler issues a one-cycle step enable every div_max+1 enabled cycles;
//   each step moves q up or down within 0..MAX_VAL, wrapping or saturating
//   at the terminal value.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, highest priority
//   en        prescaler enable; low freezes prescaler and counter
//   div_max   prescaler terminal value (step every div_max+1 enabled cycles)
//   dir       1 = count up, 0 = count down (sampled on step cycles only)
//   sat       0 = wrap, 1 = saturate at terminal value (sampled on steps)
//   load      synchronous load strobe, wins over a coincident step
//   load_val  value to load, clamped to MAX_VAL
//   q         registered count value
//   tick      one-cycle pulse when q has just stepped
//   tc        one-cycle pulse when that step started at the terminal value
module prescaled_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = 2**WIDTH-1,
  parameter int unsigned DIV_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_max,
  input  logic                 dir,
  input  logic                 sat,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     q,
  output logic                 tick,
  output logic                 tc
);

  // Compares run one bit wider so MAX_VAL = 2**WIDTH-1 never overflows.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

  logic [DIV_WIDTH-1:0] pcnt;
  logic                 rollover;
  logic                 at_term;
  logic [WIDTH-1:0]     q_step;
  logic [WIDTH-1:0]     load_clamped;

  always_comb begin
    // >= rather than == so lowering div_max mid-count rolls over at once.
    rollover = en && (pcnt >= div_max);

    if (dir) at_term = ({1'b0, q} >= MAX_EXT);
    else     at_term = (q == '0);

    q_step = q;
    if (at_term) begin
      if (!sat) q_step = dir ? '0 : MAX_Q;
    end else begin
      // Not at the terminal value, so neither direction can leave 0..MAX_VAL.
      q_step = dir ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    end

    load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      q    <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (load) begin
      pcnt <= '0;
      q    <= load_clamped;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
      if (rollover) begin
        pcnt <= '0;
        q    <= q_step;
        tick <= 1'b1;
        tc   <= at_term;
      end else if (en) begin
        pcnt <= pcnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
module tb_prescaled_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [24:0] div_max = '0;
  logic        dir = 1'b1;
  logic        sat = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  load_val = '0;
  logic [3:0]  q_o [2];
  logic        tick_o [2];
  logic        tc_o [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: shared prescaler, one counter per instance.
  int unsigned m_pcnt = 0;
  int unsigned m_q [2] = '{0, 0};
  logic        m_tick [2] = '{1'b0, 1'b0};
  logic        m_tc [2] = '{1'b0, 1'b0};
  int unsigned mx [2] = '{15, 9};

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(4), .MAX_VAL(15), .DIV_WIDTH(25)) dut_full (
    .clk(clk), .rst(rst), .en(en), .div_max(div_max), .dir(dir), .sat(sat),
    .load(load), .load_val(load_val), .q(q_o[0]), .tick(tick_o[0]), .tc(tc_o[0])
  );

  prescaled_counter #(.WIDTH(4), .MAX_VAL(9), .DIV_WIDTH(25)) dut_dec (
    .clk(clk), .rst(rst), .en(en), .div_max(div_max), .dir(dir), .sat(sat),
    .load(load), .load_val(load_val), .q(q_o[1]), .tick(tick_o[1]), .tc(tc_o[1])
  );

  function automatic int unsigned next_q(int unsigned cur, int unsigned top, logic up, logic s);
    if (up) return s ? ((cur + 1 > top) ? top : cur + 1) : (cur + 1) % (top + 1);
    else    return s ? ((cur == 0) ? 0 : cur - 1) : (cur + top) % (top + 1);
  endfunction

  // One clock: model consumes the inputs seen at the edge; outputs sampled 1 time unit later.
  task automatic clk_cycle();
    bit stp;
    @(posedge clk);
    if (rst) begin
      m_pcnt = 0;
      for (int i = 0; i < 2; i++) begin m_q[i] = 0; m_tick[i] = 0; m_tc[i] = 0; end
    end else if (load) begin
      m_pcnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_q[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
        m_tick[i] = 0; m_tc[i] = 0;
      end
    end else begin
      stp = en && (m_pcnt >= int'(div_max));
      for (int i = 0; i < 2; i++) begin
        m_tick[i] = stp;
        m_tc[i] = stp && (m_q[i] == (dir ? mx[i] : 0));
        if (stp) m_q[i] = next_q(m_q[i], mx[i], dir, sat);
      end
      if (stp) m_pcnt = 0;
      else if (en) m_pcnt = m_pcnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; load = 0; div_max = 25'd3; dir = 1; sat = 0;
    clk_cycle(); clk_cycle();
    n_vec++; if (q_o[0] !== 4'd0)   begin n_err++; $display("FAIL reset_q: got %0d want 0", q_o[0]); end
    n_vec++; if (tick_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick_o[0]); end
    n_vec++; if (tc_o[0] !== 1'b0)   begin n_err++; $display("FAIL reset_tc: got %b want 0", tc_o[0]); end
    n_vec++; if (q_o[1] !== 4'd0)   begin n_err++; $display("FAIL reset_q_dec: got %0d want 0", q_o[1]); end
  endtask

  task automatic test_count_up();
    int unsigned eq;
    rst = 0; en = 1; div_max = 25'd3; dir = 1; sat = 0;
    for (int c = 1; c <= 64; c++) begin
      clk_cycle();
      eq = (c / 4) % 16;
      n_vec++; if (tick_o[0] !== ((c % 4) == 0)) begin n_err++; $display("FAIL up_tick c=%0d: got %b want %b", c, tick_o[0], (c % 4) == 0); end
      n_vec++; if (q_o[0] !== 4'(eq)) begin n_err++; $display("FAIL up_q c=%0d: got %0d want %0d", c, q_o[0], eq); end
      n_vec++; if (tc_o[0] !== (c == 64)) begin n_err++; $display("FAIL up_tc c=%0d: got %b want %b", c, tc_o[0], c == 64); end
    end
    n_vec++; if (q_o[1] !== 4'd6) begin n_err++; $display("FAIL up_q_dec: got %0d want 6", q_o[1]); end
  endtask

  task automatic test_sat_down();
    int unsigned exp_q [5] = '{1, 0, 0, 0, 0};
    logic exp_tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load = 1; load_val = 4'd2;
    clk_cycle();
    load = 0;
    n_vec++; if (q_o[0] !== 4'd2) begin n_err++; $display("FAIL sat_load_q: got %0d want 2", q_o[0]); end
    n_vec++; if (tick_o[0] !== 1'b0) begin n_err++; $display("FAIL sat_load_tick: got %b want 0", tick_o[0]); end
    dir = 0; sat = 1; div_max = 25'd0;
    for (int k = 0; k < 5; k++) begin
      clk_cycle();
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (q_o[i] !== 4'(exp_q[k])) begin n_err++; $display("FAIL sat_q[%0d] k=%0d: got %0d want %0d", i, k, q_o[i], exp_q[k]); end
        n_vec++; if (tc_o[i] !== exp_tc[k]) begin n_err++; $display("FAIL sat_tc[%0d] k=%0d: got %b want %b", i, k, tc_o[i], exp_tc[k]); end
        n_vec++; if (tick_o[i] !== 1'b1) begin n_err++; $display("FAIL sat_tick[%0d] k=%0d: got %b want 1", i, k, tick_o[i]); end
      end
    end
  endtask

  task automatic test_nonpow2();
    load = 1; load_val = 4'd12;
    clk_cycle();
    load = 0;
    n_vec++; if (q_o[1] !== 4'd9)  begin n_err++; $display("FAIL np2_clamp: got %0d want 9", q_o[1]); end
    n_vec++; if (q_o[0] !== 4'd12) begin n_err++; $display("FAIL np2_noclamp: got %0d want 12", q_o[0]); end
    dir = 1; sat = 0; div_max = 25'd0;
    clk_cycle();
    n_vec++; if (q_o[1] !== 4'd0) begin n_err++; $display("FAIL np2_wrap_q: got %0d want 0", q_o[1]); end
    n_vec++; if (tc_o[1] !== 1'b1) begin n_err++; $display("FAIL np2_wrap_tc: got %b want 1", tc_o[1]); end
    n_vec++; if (q_o[0] !== 4'd13) begin n_err++; $display("FAIL np2_full_q: got %0d want 13", q_o[0]); end
    n_vec++; if (tc_o[0] !== 1'b0) begin n_err++; $display("FAIL np2_full_tc: got %b want 0", tc_o[0]); end
    for (int c = 0; c < 100; c++) begin
      dir = 1'($urandom); sat = 1'($urandom);
      clk_cycle();
      n_vec++; if (q_o[1] > 4'd9) begin n_err++; $display("FAIL np2_range c=%0d: got %0d want <=9", c, q_o[1]); end
      n_vec++; if (q_o[1] !== 4'(m_q[1])) begin n_err++; $display("FAIL np2_model c=%0d: got %0d want %0d", c, q_o[1], m_q[1]); end
    end
  endtask

  task automatic test_collision_pause();
    rst = 1; clk_cycle();
    rst = 0; en = 1; div_max = 25'd3; dir = 1; sat = 0; load = 0;
    repeat (3) clk_cycle();
    load = 1; load_val = 4'd5;       // prescaler is at its rollover cycle
    clk_cycle();
    load = 0;
    n_vec++; if (q_o[0] !== 4'd5)  begin n_err++; $display("FAIL coll_q: got %0d want 5", q_o[0]); end
    n_vec++; if (tick_o[0] !== 1'b0) begin n_err++; $display("FAIL coll_tick: got %b want 0", tick_o[0]); end
    for (int k = 1; k <= 4; k++) begin
      clk_cycle();
      n_vec++; if (tick_o[0] !== (k == 4)) begin n_err++; $display("FAIL coll_next_tick k=%0d: got %b want %b", k, tick_o[0], k == 4); end
      n_vec++; if (q_o[0] !== ((k == 4) ? 4'd6 : 4'd5)) begin n_err++; $display("FAIL coll_next_q k=%0d: got %0d", k, q_o[0]); end
    end
    repeat (2) clk_cycle();
    en = 0;
    for (int k = 0; k < 10; k++) begin
      clk_cycle();
      n_vec++; if (q_o[0] !== 4'd6 || tick_o[0] !== 1'b0) begin n_err++; $display("FAIL pause k=%0d: got q=%0d tick=%b want q=6 tick=0", k, q_o[0], tick_o[0]); end
    end
    en = 1;
    clk_cycle();
    n_vec++; if (tick_o[0] !== 1'b0) begin n_err++; $display("FAIL resume_early: got tick=%b want 0", tick_o[0]); end
    clk_cycle();
    n_vec++; if (tick_o[0] !== 1'b1 || q_o[0] !== 4'd7) begin n_err++; $display("FAIL resume_tick: got q=%0d tick=%b want q=7 tick=1", q_o[0], tick_o[0]); end
  endtask

  task automatic test_mid_change();
    rst = 1; clk_cycle();
    rst = 0; en = 1; div_max = 25'd7; dir = 1; sat = 0;
    repeat (5) clk_cycle();
    div_max = 25'd1;                 // prescaler now at 5, above the new terminal
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_vec++; if (tick_o[0] !== ((k % 2) == 1)) begin n_err++; $display("FAIL divchg_tick k=%0d: got %b want %b", k, tick_o[0], (k % 2) == 1); end
      n_vec++; if (q_o[0] !== 4'((k + 1) / 2)) begin n_err++; $display("FAIL divchg_q k=%0d: got %0d want %0d", k, q_o[0], (k + 1) / 2); end
    end
    load = 1; load_val = 4'd7; clk_cycle();
    load = 0; div_max = 25'd3;
    repeat (2) clk_cycle();
    n_vec++; if (q_o[0] !== 4'd7) begin n_err++; $display("FAIL midrst_pre_q: got %0d want 7", q_o[0]); end
    rst = 1; clk_cycle();
    n_vec++; if (q_o[0] !== 4'd0 || tick_o[0] !== 1'b0 || tc_o[0] !== 1'b0) begin n_err++; $display("FAIL midrst_out: got q=%0d tick=%b tc=%b want 0/0/0", q_o[0], tick_o[0], tc_o[0]); end
    rst = 0;
    for (int k = 1; k <= 4; k++) begin
      clk_cycle();
      n_vec++; if (tick_o[0] !== (k == 4)) begin n_err++; $display("FAIL midrst_tick k=%0d: got %b want %b", k, tick_o[0], k == 4); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom);
      en = ($urandom_range(0, 3) != 0);
      div_max = 25'($urandom_range(0, 4));
      dir = 1'($urandom); sat = 1'($urandom);
      clk_cycle();
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (q_o[i] !== 4'(m_q[i]) || tick_o[i] !== m_tick[i] || tc_o[i] !== m_tc[i]) begin
          n_err++;
          $display("FAIL rand[%0d] c=%0d: got q=%0d tick=%b tc=%b want q=%0d tick=%b tc=%b",
                   i, c, q_o[i], tick_o[i], tc_o[i], m_q[i], m_tick[i], m_tc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_sat_down();
    test_nonpow2();
    test_collision_pause();
    test_mid_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
